// File: rtl/peripheral_adder_pipe.sv
// peripheral_adder_pipe: valid/ready arithmetic pipeline with an ADD, SUB,
// ACC and CLR operation set. The result is computed at the accept edge,
// passes through a second stage register, and then reaches the output
// register. A single advance enable moves every stage together.
module peripheral_adder_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_t;

  logic                  en;
  logic                  accept;

  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [ACC_WIDTH-1:0]  res_d;
  logic                  ovf_d;

  logic [DATA_WIDTH:0]   add_res;
  logic [DATA_WIDTH:0]   sub_res;
  logic [ACC_WIDTH:0]    acc_sum;

  logic                  s1_valid;
  logic [ACC_WIDTH-1:0]  s1_res;
  logic                  s1_ovf;
  logic                  s2_valid;
  logic [ACC_WIDTH-1:0]  s2_res;
  logic                  s2_ovf;

  // The whole pipe moves as one; the output slot frees when empty or consumed.
  // During reset the pipe is reported ready, but accept is masked so nothing enters.
  assign en       = !out_valid || out_ready;
  assign in_ready = rst || en;
  assign accept   = in_valid && en && !rst;

  assign add_res = {1'b0, in1} + {1'b0, in2};
  assign sub_res = {1'b0, in1} - {1'b0, in2};
  assign acc_sum = {1'b0, acc} + (ACC_WIDTH+1)'(in1);

  // Operation decode: stage-1 result, overflow flag and next accumulator value.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    acc_d = acc;
    case (mode_t'(mode))
      MODE_ADD: begin
        res_d = ACC_WIDTH'(add_res);
      end
      MODE_SUB: begin
        res_d = ACC_WIDTH'(signed'(sub_res));
        ovf_d = sub_res[DATA_WIDTH];
      end
      MODE_ACC: begin
        ovf_d = acc_sum[ACC_WIDTH];
        if (acc_sum[ACC_WIDTH] && (SATURATE != 0)) begin
          acc_d = '1;
        end else begin
          acc_d = acc_sum[ACC_WIDTH-1:0];
        end
        res_d = acc_d;
      end
      MODE_CLR: begin
        acc_d = ACC_WIDTH'(in1);
        res_d = acc_d;
      end
      default: begin
        res_d = '0;
      end
    endcase
  end

  // Accumulator commits at the accept edge so chained ACC/CLR beats see it at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= acc_d;
    end
  end

  // Stage registers and output register advance together under en; reset empties them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_res    <= '0;
      s1_ovf    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_res    <= '0;
      s2_ovf    <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      s1_valid  <= accept;
      if (accept) begin
        s1_res <= res_d;
        s1_ovf <= ovf_d;
      end
      s2_valid  <= s1_valid;
      s2_res    <= s1_res;
      s2_ovf    <= s1_ovf;
      out_valid <= s2_valid;
      out       <= s2_res;
      overflow  <= s2_ovf;
    end
  end

endmodule

// File: tb/tb_peripheral_adder_pipe.sv
// Directed bench for peripheral_adder_pipe: one wrapping and one saturating
// instance are driven with identical stimulus.
module tb_peripheral_adder_pipe;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ACC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = ADD;
  logic [7:0]  in1 = '0;
  logic [7:0]  in2 = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, overflow;
  logic [15:0] out;
  logic        in_ready_s, out_valid_s, overflow_s;
  logic [15:0] out_s;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  peripheral_adder_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .overflow(overflow)
  );

  peripheral_adder_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .mode(mode), .in1(in1), .in2(in2), .out_valid(out_valid_s),
    .out_ready(out_ready), .out(out_s), .overflow(overflow_s)
  );

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge.
  task automatic beat(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    mode = m;
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    mode = ADD;
    in1 = 8'd1;
    in2 = 8'd1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out !== 16'h0000 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b out=%h ov=%b exp v=0 out=0000 ov=0",
               out_valid, out, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_accept cycle=%0d got v=%b exp v=0", i, out_valid);
      end
    end
  endtask

  task automatic test_add();
    beat(ADD, 8'd5, 8'd2);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_latency_n got v=%b exp 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_latency_n1 got v=%b exp 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0007 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL add_5_2 got v=%b out=%h ov=%b exp v=1 out=0007 ov=0",
               out_valid, out, overflow);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_bubble got v=%b exp 0", out_valid);
    end
    beat(ADD, 8'd255, 8'd255);
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h01FE || overflow !== 1'b0) begin
      failures++;
      $display("FAIL add_255_255 got v=%b out=%h ov=%b exp v=1 out=01fe ov=0",
               out_valid, out, overflow);
    end
    step();
  endtask

  task automatic test_sub();
    beat(SUB, 8'd2, 8'd5);
    beat(SUB, 8'd9, 8'd4);
    step();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'hFFFD || overflow !== 1'b1) begin
      failures++;
      $display("FAIL sub_2_5 got v=%b out=%h ov=%b exp v=1 out=fffd ov=1",
               out_valid, out, overflow);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0005 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL sub_9_4 got v=%b out=%h ov=%b exp v=1 out=0005 ov=0",
               out_valid, out, overflow);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_out [3];
    exp_out[0] = 16'd10;
    exp_out[1] = 16'd30;
    exp_out[2] = 16'd60;
    beat(CLR, 8'd10, 8'd0);
    beat(ACC, 8'd20, 8'd0);
    beat(ACC, 8'd30, 8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out !== exp_out[i] || overflow !== 1'b0 ||
          out_s !== exp_out[i]) begin
        failures++;
        $display("FAIL b2b_acc idx=%0d got v=%b out=%h ov=%b sat_out=%h exp v=1 out=%h ov=0",
                 i, out_valid, out, overflow, out_s, exp_out[i]);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    beat(CLR, 8'd255, 8'd0);
    for (int i = 0; i < 256; i++) beat(ACC, 8'd255, 8'd0);
    step();
    step();
    checks++;
    if (out !== 16'hFFFF || overflow !== 1'b0 || out_s !== 16'hFFFF || overflow_s !== 1'b0) begin
      failures++;
      $display("FAIL acc_full got out=%h ov=%b sat_out=%h sat_ov=%b exp ffff 0 ffff 0",
               out, overflow, out_s, overflow_s);
    end
    step();
    beat(ACC, 8'd1, 8'd0);
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0000 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL acc_wrap got v=%b out=%h ov=%b exp v=1 out=0000 ov=1",
               out_valid, out, overflow);
    end
    checks++;
    if (out_valid_s !== 1'b1 || out_s !== 16'hFFFF || overflow_s !== 1'b1) begin
      failures++;
      $display("FAIL acc_sat got v=%b out=%h ov=%b exp v=1 out=ffff ov=1",
               out_valid_s, out_s, overflow_s);
    end
    step();
    beat(ACC, 8'd5, 8'd0);
    step();
    step();
    checks++;
    if (out !== 16'h0005 || overflow !== 1'b0 || out_s !== 16'hFFFF || overflow_s !== 1'b1) begin
      failures++;
      $display("FAIL acc_after_sat got out=%h ov=%b sat_out=%h sat_ov=%b exp 0005 0 ffff 1",
               out, overflow, out_s, overflow_s);
    end
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    beat(ADD, 8'd1, 8'd1);
    beat(ADD, 8'd2, 8'd2);
    beat(ADD, 8'd3, 8'd3);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 16'd2) begin
      failures++;
      $display("FAIL stall_full got rdy=%b v=%b out=%h exp rdy=0 v=1 out=0002",
               in_ready, out_valid, out);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 16'd2 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got rdy=%b v=%b out=%h ov=%b exp rdy=0 v=1 out=0002 ov=0",
                 i, in_ready, out_valid, out, overflow);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'd4) begin
      failures++;
      $display("FAIL stall_out2 got v=%b out=%h exp v=1 out=0004", out_valid, out);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'd6) begin
      failures++;
      $display("FAIL stall_out3 got v=%b out=%h exp v=1 out=0006", out_valid, out);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    beat(CLR, 8'd10, 8'd0);
    beat(ACC, 8'd20, 8'd0);
    beat(ACC, 8'd30, 8'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out !== 16'h0000 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got v=%b out=%h ov=%b exp v=0 out=0000 ov=0",
               out_valid, out, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_stale cycle=%0d got v=%b exp 0", i, out_valid);
      end
    end
    beat(ACC, 8'd7, 8'd0);
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0007 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_acc7 got v=%b out=%h ov=%b exp v=1 out=0007 ov=0",
               out_valid, out, overflow);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_saturate();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
